// File: rtl/mem_controller_rr_if.sv
// Signal bundle between the LSU consumers, the round-robin memory controller
// and the external memory channels.
interface mem_controller_rr_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;
  logic [NUM_CHANNELS-1:0]                 mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_ready;
  logic [NUM_CHANNELS-1:0]                 channel_busy;
  logic [NUM_CHANNELS-1:0]                 timeout_flag;

  modport master (
    input  consumer_read_valid, consumer_read_address, consumer_write_valid,
           consumer_write_address, consumer_write_data, mem_read_ready,
           mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address, mem_write_valid, mem_write_address,
           mem_write_data, channel_busy, timeout_flag
  );

  modport slave (
    output consumer_read_valid, consumer_read_address, consumer_write_valid,
           consumer_write_address, consumer_write_data, mem_read_ready,
           mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address, mem_write_valid, mem_write_address,
           mem_write_data, channel_busy, timeout_flag
  );
endinterface

// File: rtl/mem_controller_rr.sv
// Multi-channel memory controller: round-robin grants of consumer transactions
// onto independent memory channels, with optional per-channel wait timeout.
module mem_controller_rr #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int NUM_CHANNELS   = 2,
  parameter bit WRITE_ENABLE   = 1'b1,
  parameter bit READ_FIRST     = 1'b1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic             clk,
  input logic             reset,
  mem_controller_rr_if.master bus
);
  localparam int CW = $clog2(NUM_CONSUMERS);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] IDLE           = 3'd0;
  localparam logic [2:0] READ_WAITING   = 3'd1;
  localparam logic [2:0] WRITE_WAITING  = 3'd2;
  localparam logic [2:0] READ_RELAYING  = 3'd3;
  localparam logic [2:0] WRITE_RELAYING = 3'd4;

  logic [2:0]               state            [NUM_CHANNELS];
  logic [CW-1:0]            current_consumer [NUM_CHANNELS];
  logic [TW-1:0]            timeout_count    [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] owner;
  logic [CW-1:0]            rr_ptr;

  logic [NUM_CONSUMERS-1:0] requesting;
  logic [NUM_CHANNELS-1:0]  grant_vld;
  logic [NUM_CHANNELS-1:0]  grant_rd;
  logic [NUM_CHANNELS-1:0]  timeout_hit;
  logic [CW-1:0]            grant_idx [NUM_CHANNELS];
  logic [CW-1:0]            next_ptr;
  logic                     any_grant;

  assign requesting = bus.consumer_read_valid |
                      (bus.consumer_write_valid & {NUM_CONSUMERS{WRITE_ENABLE}});

  // Idle channels claim consumers in ascending channel order; 'taken' keeps a
  // consumer from being handed to two channels in the same cycle.
  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    logic [CW-1:0]            idx;
    taken     = '0;
    idx       = '0;
    grant_vld = '0;
    grant_rd  = '0;
    any_grant = 1'b0;
    next_ptr  = rr_ptr;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_idx[ch] = '0;
      if (state[ch] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx = CW'((int'(rr_ptr) + k) % NUM_CONSUMERS);
          if (!grant_vld[ch] && requesting[idx] && !owner[idx] && !taken[idx]) begin
            grant_vld[ch] = 1'b1;
            grant_idx[ch] = idx;
            taken[idx]    = 1'b1;
            grant_rd[ch]  = bus.consumer_read_valid[idx] &
                            (READ_FIRST | ~(bus.consumer_write_valid[idx] & WRITE_ENABLE));
            any_grant     = 1'b1;
            next_ptr      = CW'((int'(idx) + 1) % NUM_CONSUMERS);
          end
        end
      end
    end
  end

  always_comb begin
    bus.channel_busy = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      bus.channel_busy[ch] = (state[ch] != IDLE);
      timeout_hit[ch]      = (TIMEOUT_CYCLES > 0) &&
                             (timeout_count[ch] == TW'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner                    <= '0;
      rr_ptr                   <= '0;
      bus.consumer_read_ready  <= '0;
      bus.consumer_read_data   <= '0;
      bus.consumer_write_ready <= '0;
      bus.mem_read_valid       <= '0;
      bus.mem_read_address     <= '0;
      bus.mem_write_valid      <= '0;
      bus.mem_write_address    <= '0;
      bus.mem_write_data       <= '0;
      bus.timeout_flag         <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state[ch]            <= IDLE;
        current_consumer[ch] <= '0;
        timeout_count[ch]    <= '0;
      end
    end else begin
      if (any_grant) rr_ptr <= next_ptr;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state[ch])
          IDLE: begin
            if (grant_vld[ch]) begin
              owner[grant_idx[ch]] <= 1'b1;
              current_consumer[ch] <= grant_idx[ch];
              timeout_count[ch]    <= '0;
              if (grant_rd[ch]) begin
                bus.mem_read_valid[ch]   <= 1'b1;
                bus.mem_read_address[ch] <= ADDR_BITS'(bus.consumer_read_address[grant_idx[ch]]);
                state[ch]                <= READ_WAITING;
              end else begin
                bus.mem_write_valid[ch]   <= 1'b1;
                bus.mem_write_address[ch] <= ADDR_BITS'(bus.consumer_write_address[grant_idx[ch]]);
                bus.mem_write_data[ch]    <= DATA_BITS'(bus.consumer_write_data[grant_idx[ch]]);
                state[ch]                 <= WRITE_WAITING;
              end
            end
          end
          // A memory ready on the timeout edge takes precedence over the abort.
          READ_WAITING: begin
            if (bus.mem_read_ready[ch]) begin
              bus.mem_read_valid[ch]                           <= 1'b0;
              bus.consumer_read_ready[current_consumer[ch]]    <= 1'b1;
              bus.consumer_read_data[current_consumer[ch]]     <= bus.mem_read_data[ch];
              timeout_count[ch]                                <= '0;
              state[ch]                                        <= READ_RELAYING;
            end else if (timeout_hit[ch]) begin
              bus.mem_read_valid[ch]                           <= 1'b0;
              bus.consumer_read_ready[current_consumer[ch]]    <= 1'b1;
              bus.consumer_read_data[current_consumer[ch]]     <= {DATA_BITS{1'b1}};
              bus.timeout_flag[ch]                             <= 1'b1;
              timeout_count[ch]                                <= '0;
              state[ch]                                        <= READ_RELAYING;
            end else begin
              timeout_count[ch] <= timeout_count[ch] + 1'b1;
            end
          end
          WRITE_WAITING: begin
            if (bus.mem_write_ready[ch] || timeout_hit[ch]) begin
              bus.mem_write_valid[ch]                        <= 1'b0;
              bus.consumer_write_ready[current_consumer[ch]] <= 1'b1;
              timeout_count[ch]                              <= '0;
              state[ch]                                      <= WRITE_RELAYING;
              if (!bus.mem_write_ready[ch]) bus.timeout_flag[ch] <= 1'b1;
            end else begin
              timeout_count[ch] <= timeout_count[ch] + 1'b1;
            end
          end
          READ_RELAYING: begin
            if (!bus.consumer_read_valid[current_consumer[ch]]) begin
              bus.consumer_read_ready[current_consumer[ch]] <= 1'b0;
              owner[current_consumer[ch]]                   <= 1'b0;
              state[ch]                                     <= IDLE;
            end
          end
          WRITE_RELAYING: begin
            if (!bus.consumer_write_valid[current_consumer[ch]]) begin
              bus.consumer_write_ready[current_consumer[ch]] <= 1'b0;
              owner[current_consumer[ch]]                    <= 1'b0;
              state[ch]                                      <= IDLE;
            end
          end
          default: state[ch] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_controller_rr.sv
// Bench for mem_controller_rr: directed scenarios plus a randomized run against
// a transaction-level consumer/memory model.
module tb_mem_controller_rr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_controller_rr_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) bm();
  mem_controller_rr_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) bw();
  mem_controller_rr_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) bo();

  mem_controller_rr #(.WRITE_ENABLE(1'b1), .READ_FIRST(1'b1), .TIMEOUT_CYCLES(8))
    u_main (.clk(clk), .reset(reset), .bus(bm));
  mem_controller_rr #(.WRITE_ENABLE(1'b1), .READ_FIRST(1'b0), .TIMEOUT_CYCLES(0))
    u_wfirst (.clk(clk), .reset(reset), .bus(bw));
  mem_controller_rr #(.WRITE_ENABLE(1'b0), .READ_FIRST(1'b1), .TIMEOUT_CYCLES(0))
    u_ronly (.clk(clk), .reset(reset), .bus(bo));

  function automatic logic [15:0] hash(input logic [7:0] a);
    return {a ^ 8'hC3, ~a};
  endfunction

  task automatic clear_inputs();
    bm.consumer_read_valid = '0; bm.consumer_read_address = '0;
    bm.consumer_write_valid = '0; bm.consumer_write_address = '0; bm.consumer_write_data = '0;
    bm.mem_read_ready = '0; bm.mem_read_data = '0; bm.mem_write_ready = '0;
    bw.consumer_read_valid = '0; bw.consumer_read_address = '0;
    bw.consumer_write_valid = '0; bw.consumer_write_address = '0; bw.consumer_write_data = '0;
    bw.mem_read_ready = '0; bw.mem_read_data = '0; bw.mem_write_ready = '0;
    bo.consumer_read_valid = '0; bo.consumer_read_address = '0;
    bo.consumer_write_valid = '0; bo.consumer_write_address = '0; bo.consumer_write_data = '0;
    bo.mem_read_ready = '0; bo.mem_read_data = '0; bo.mem_write_ready = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bm.mem_read_valid !== 2'b00) begin failures++; $display("FAIL reset_mem_read_valid got %b want 00", bm.mem_read_valid); end
    checks++; if (bm.mem_write_valid !== 2'b00) begin failures++; $display("FAIL reset_mem_write_valid got %b want 00", bm.mem_write_valid); end
    checks++; if (bm.consumer_read_ready !== 4'b0000) begin failures++; $display("FAIL reset_read_ready got %b want 0000", bm.consumer_read_ready); end
    checks++; if (bm.consumer_write_ready !== 4'b0000) begin failures++; $display("FAIL reset_write_ready got %b want 0000", bm.consumer_write_ready); end
    checks++; if (bm.consumer_read_data !== 64'h0) begin failures++; $display("FAIL reset_read_data got %h want 0", bm.consumer_read_data); end
    checks++; if (bm.channel_busy !== 2'b00) begin failures++; $display("FAIL reset_busy got %b want 00", bm.channel_busy); end
    checks++; if (bm.timeout_flag !== 2'b00) begin failures++; $display("FAIL reset_timeout_flag got %b want 00", bm.timeout_flag); end
    checks++; if (bm.mem_read_address !== 16'h0) begin failures++; $display("FAIL reset_mem_read_address got %h want 0", bm.mem_read_address); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int vcnt;
    do_reset();
    bm.consumer_read_valid[2] = 1'b1;
    bm.consumer_read_address[2] = 8'h3C;
    @(negedge clk);
    checks++; if (bm.mem_read_valid !== 2'b01) begin failures++; $display("FAIL single_grant got %b want 01", bm.mem_read_valid); end
    checks++; if (bm.mem_read_address[0] !== 8'h3C) begin failures++; $display("FAIL single_addr got %h want 3c", bm.mem_read_address[0]); end
    vcnt = 1;
    @(negedge clk); if (bm.mem_read_valid[0]) vcnt++;
    @(negedge clk); if (bm.mem_read_valid[0]) vcnt++;
    bm.mem_read_ready[0] = 1'b1;
    bm.mem_read_data[0] = 16'hBEEF;
    @(negedge clk);
    checks++; if (vcnt != 3 || bm.mem_read_valid[0] !== 1'b0) begin failures++; $display("FAIL single_valid_len got %0d/%b want 3/0", vcnt, bm.mem_read_valid[0]); end
    checks++; if (bm.consumer_read_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got %b want 0100", bm.consumer_read_ready); end
    checks++; if (bm.consumer_read_data[2] !== 16'hBEEF) begin failures++; $display("FAIL single_data got %h want beef", bm.consumer_read_data[2]); end
    bm.mem_read_ready[0] = 1'b0;
    bm.consumer_read_valid[2] = 1'b0;
    @(negedge clk);
    checks++; if (bm.consumer_read_ready !== 4'b0000 || bm.channel_busy !== 2'b00) begin failures++; $display("FAIL single_release got ready=%b busy=%b want 0000/00", bm.consumer_read_ready, bm.channel_busy); end
    checks++; if (bm.consumer_read_data[2] !== 16'hBEEF) begin failures++; $display("FAIL single_data_hold got %h want beef", bm.consumer_read_data[2]); end
  endtask

  task automatic test_exclusivity();
    do_reset();
    bm.consumer_read_valid[1] = 1'b1;
    bm.consumer_read_address[1] = 8'h51;
    @(negedge clk);
    checks++; if (bm.channel_busy !== 2'b01 || bm.mem_read_valid !== 2'b01) begin failures++; $display("FAIL excl_grant got busy=%b valid=%b want 01/01", bm.channel_busy, bm.mem_read_valid); end
    @(negedge clk);
    checks++; if (bm.channel_busy !== 2'b01) begin failures++; $display("FAIL excl_ch1_idle got busy=%b want 01", bm.channel_busy); end
    bm.mem_read_ready[0] = 1'b1;
    bm.mem_read_data[0] = 16'h0A0B;
    @(negedge clk);
    checks++; if (bm.consumer_read_ready !== 4'b0010 || bm.channel_busy !== 2'b01) begin failures++; $display("FAIL excl_done got ready=%b busy=%b want 0010/01", bm.consumer_read_ready, bm.channel_busy); end
    bm.mem_read_ready[0] = 1'b0;
    bm.consumer_read_valid[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int gq[$];
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bm.consumer_read_valid[c] = 1'b1;
      bm.consumer_read_address[c] = 8'(c);
    end
    for (int i = 0; i < 40 && gq.size() < 6; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (bm.mem_read_valid[ch] && !bm.mem_read_ready[ch]) begin
          gq.push_back(int'(bm.mem_read_address[ch]));
          bm.mem_read_ready[ch] = 1'b1;
          bm.mem_read_data[ch] = 16'h1000;
        end else begin
          bm.mem_read_ready[ch] = 1'b0;
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (bm.consumer_read_valid[c] && bm.consumer_read_ready[c]) bm.consumer_read_valid[c] = 1'b0;
        else if (!bm.consumer_read_valid[c] && !bm.consumer_read_ready[c]) bm.consumer_read_valid[c] = 1'b1;
      end
    end
    checks++; if (gq.size() < 6) begin failures++; $display("FAIL fair_progress got %0d grants want 6", gq.size()); end
    for (int k = 0; k < 6 && k < gq.size(); k++) begin
      checks++; if (gq[k] != k % 4) begin failures++; $display("FAIL fair_order[%0d] got consumer %0d want %0d", k, gq[k], k % 4); end
    end
  endtask

  task automatic test_priority();
    do_reset();
    bm.consumer_read_valid[0] = 1'b1; bm.consumer_read_address[0] = 8'h11;
    bm.consumer_write_valid[0] = 1'b1; bm.consumer_write_address[0] = 8'h22; bm.consumer_write_data[0] = 16'h1234;
    bw.consumer_read_valid[0] = 1'b1; bw.consumer_read_address[0] = 8'h11;
    bw.consumer_write_valid[0] = 1'b1; bw.consumer_write_address[0] = 8'h22; bw.consumer_write_data[0] = 16'h1234;
    bo.consumer_read_valid[0] = 1'b1; bo.consumer_read_address[0] = 8'h11;
    bo.consumer_write_valid[0] = 1'b1; bo.consumer_write_address[0] = 8'h22; bo.consumer_write_data[0] = 16'h1234;
    @(negedge clk);
    checks++; if (bm.mem_read_valid !== 2'b01 || bm.mem_write_valid !== 2'b00 || bm.mem_read_address[0] !== 8'h11) begin failures++; $display("FAIL prio_read_first got rv=%b wv=%b a=%h want 01/00/11", bm.mem_read_valid, bm.mem_write_valid, bm.mem_read_address[0]); end
    checks++; if (bw.mem_write_valid !== 2'b01 || bw.mem_read_valid !== 2'b00) begin failures++; $display("FAIL prio_write_first got wv=%b rv=%b want 01/00", bw.mem_write_valid, bw.mem_read_valid); end
    checks++; if (bw.mem_write_address[0] !== 8'h22 || bw.mem_write_data[0] !== 16'h1234) begin failures++; $display("FAIL prio_write_pass got a=%h d=%h want 22/1234", bw.mem_write_address[0], bw.mem_write_data[0]); end
    checks++; if (bo.mem_read_valid !== 2'b01 || bo.mem_write_valid !== 2'b00) begin failures++; $display("FAIL prio_read_only got rv=%b wv=%b want 01/00", bo.mem_read_valid, bo.mem_write_valid); end
    bm.mem_read_ready[0] = 1'b1; bm.mem_read_data[0] = 16'h5555;
    bw.mem_write_ready[0] = 1'b1;
    bo.mem_read_ready[0] = 1'b1; bo.mem_read_data[0] = 16'h6666;
    @(negedge clk);
    checks++; if (bm.consumer_read_ready !== 4'b0001 || bm.consumer_write_ready !== 4'b0000) begin failures++; $display("FAIL prio_rf_done got r=%b w=%b want 0001/0000", bm.consumer_read_ready, bm.consumer_write_ready); end
    checks++; if (bw.consumer_write_ready !== 4'b0001 || bw.consumer_read_ready !== 4'b0000) begin failures++; $display("FAIL prio_wf_done got w=%b r=%b want 0001/0000", bw.consumer_write_ready, bw.consumer_read_ready); end
    checks++; if (bo.consumer_read_ready !== 4'b0001 || bo.consumer_read_data[0] !== 16'h6666) begin failures++; $display("FAIL prio_ro_done got r=%b d=%h want 0001/6666", bo.consumer_read_ready, bo.consumer_read_data[0]); end
    clear_inputs();
    repeat (2) @(negedge clk);
    bo.consumer_write_valid[1] = 1'b1; bo.consumer_write_address[1] = 8'h33; bo.consumer_write_data[1] = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bo.mem_write_valid !== 2'b00 || bo.consumer_write_ready !== 4'b0000 || bo.channel_busy !== 2'b00) begin failures++; $display("FAIL prio_ro_write_ignored got wv=%b wr=%b busy=%b want 00/0000/00", bo.mem_write_valid, bo.consumer_write_ready, bo.channel_busy); end
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int  vcnt;
    bit  seen;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      bm.consumer_read_valid[0] = 1'b1;
      bm.consumer_read_address[0] = 8'h40 + 8'(pass);
      vcnt = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bm.consumer_read_ready[0]) begin seen = 1'b1; break; end
        if (bm.mem_read_valid[0]) vcnt++;
        if (pass == 1 && vcnt == 8) begin bm.mem_read_ready[0] = 1'b1; bm.mem_read_data[0] = 16'h1357; end
      end
      checks++; if (!seen || vcnt != 8) begin failures++; $display("FAIL timeout_wait%0d got seen=%0d waited=%0d want 1/8", pass, seen, vcnt); end
      if (pass == 0) begin
        checks++; if (bm.consumer_read_data[0] !== 16'hFFFF || bm.timeout_flag !== 2'b01) begin failures++; $display("FAIL timeout_abort got d=%h flag=%b want ffff/01", bm.consumer_read_data[0], bm.timeout_flag); end
        bm.consumer_read_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bm.timeout_flag !== 2'b01 || bm.consumer_read_ready !== 4'b0000 || bm.channel_busy !== 2'b00) begin failures++; $display("FAIL timeout_sticky got flag=%b r=%b busy=%b want 01/0000/00", bm.timeout_flag, bm.consumer_read_ready, bm.channel_busy); end
      end else begin
        checks++; if (bm.consumer_read_data[0] !== 16'h1357 || bm.timeout_flag !== 2'b00) begin failures++; $display("FAIL timeout_ready_wins got d=%h flag=%b want 1357/00", bm.consumer_read_data[0], bm.timeout_flag); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    bm.consumer_read_valid[0] = 1'b1;
    bm.consumer_read_address[0] = 8'h66;
    @(negedge clk);
    checks++; if (bm.mem_read_valid !== 2'b01) begin failures++; $display("FAIL areset_pre got %b want 01", bm.mem_read_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bm.mem_read_valid !== 2'b00 || bm.channel_busy !== 2'b00 || bm.consumer_read_ready !== 4'b0000 || bm.mem_read_address !== 16'h0) begin failures++; $display("FAIL areset_immediate got rv=%b busy=%b r=%b a=%h want all 0", bm.mem_read_valid, bm.channel_busy, bm.consumer_read_ready, bm.mem_read_address); end
    #1 reset = 1'b0;
    bm.consumer_read_valid[0] = 1'b0;
    bm.consumer_read_valid[3] = 1'b1;
    bm.consumer_read_address[3] = 8'h77;
    @(negedge clk);
    checks++; if (bm.mem_read_valid !== 2'b01 || bm.mem_read_address[0] !== 8'h77) begin failures++; $display("FAIL areset_regrant got v=%b a=%h want 01/77", bm.mem_read_valid, bm.mem_read_address[0]); end
    bm.mem_read_ready[0] = 1'b1; bm.mem_read_data[0] = 16'h2468;
    @(negedge clk);
    checks++; if (bm.consumer_read_ready !== 4'b1000 || bm.consumer_read_data[3] !== 16'h2468) begin failures++; $display("FAIL areset_complete got r=%b d=%h want 1000/2468", bm.consumer_read_ready, bm.consumer_read_data[3]); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    int phase[4], op[4], delay[4], age[4];
    bit fwd[4];
    logic [7:0]  addr[4];
    logic [15:0] wdata[4];
    int rcnt[2], wcnt[2], act[2];
    int cid, served;
    bit done;
    do_reset();
    served = 0;
    for (int c = 0; c < 4; c++) begin phase[c] = 0; delay[c] = 0; age[c] = 0; fwd[c] = 1'b0; op[c] = 0; addr[c] = '0; wdata[c] = '0; end
    for (int ch = 0; ch < 2; ch++) begin rcnt[ch] = -1; wcnt[ch] = -1; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        act[ch] = bm.mem_read_valid[ch] ? int'(bm.mem_read_address[ch][7:6]) :
                  bm.mem_write_valid[ch] ? int'(bm.mem_write_address[ch][7:6]) : -1;
      end
      if (act[0] >= 0 && act[1] >= 0) begin
        checks++; if (act[0] == act[1]) begin failures++; $display("FAIL rand_exclusive consumer %0d on both channels", act[0]); end
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (bm.mem_read_ready[ch]) bm.mem_read_ready[ch] = 1'b0;
        else if (bm.mem_read_valid[ch]) begin
          if (rcnt[ch] < 0) begin
            cid = int'(bm.mem_read_address[ch][7:6]);
            checks++; if (phase[cid] != 1 || op[cid] == 1 || fwd[cid] || addr[cid] !== bm.mem_read_address[ch]) begin failures++; $display("FAIL rand_read_req ch%0d got addr %h want %h (phase %0d op %0d)", ch, bm.mem_read_address[ch], addr[cid], phase[cid], op[cid]); end
            fwd[cid] = 1'b1;
            rcnt[ch] = $urandom_range(0, 4);
          end
          if (rcnt[ch] == 0) begin
            bm.mem_read_ready[ch] = 1'b1;
            bm.mem_read_data[ch] = hash(bm.mem_read_address[ch]);
            rcnt[ch] = -1;
          end else rcnt[ch]--;
        end
        if (bm.mem_write_ready[ch]) bm.mem_write_ready[ch] = 1'b0;
        else if (bm.mem_write_valid[ch]) begin
          if (wcnt[ch] < 0) begin
            cid = int'(bm.mem_write_address[ch][7:6]);
            checks++; if (phase[cid] != 1 || op[cid] != 1 || fwd[cid] || addr[cid] !== bm.mem_write_address[ch] || wdata[cid] !== bm.mem_write_data[ch]) begin failures++; $display("FAIL rand_write_req ch%0d got %h/%h want %h/%h (op %0d)", ch, bm.mem_write_address[ch], bm.mem_write_data[ch], addr[cid], wdata[cid], op[cid]); end
            fwd[cid] = 1'b1;
            wcnt[ch] = $urandom_range(0, 4);
          end
          if (wcnt[ch] == 0) begin bm.mem_write_ready[ch] = 1'b1; wcnt[ch] = -1; end
          else wcnt[ch]--;
        end
      end
      for (int c = 0; c < 4; c++) begin
        case (phase[c])
          0: if (delay[c] > 0) delay[c]--;
             else begin
               op[c] = $urandom_range(0, 2);
               addr[c] = {2'(c), 6'($urandom_range(0, 63))};
               wdata[c] = 16'($urandom);
               fwd[c] = 1'b0; age[c] = 0; phase[c] = 1;
               bm.consumer_read_valid[c] = (op[c] != 1);
               bm.consumer_write_valid[c] = (op[c] != 0);
               bm.consumer_read_address[c] = addr[c];
               bm.consumer_write_address[c] = addr[c];
               bm.consumer_write_data[c] = wdata[c];
             end
          1: begin
               age[c]++;
               done = (op[c] == 1) ? bm.consumer_write_ready[c] : bm.consumer_read_ready[c];
               if (done) begin
                 served++;
                 if (op[c] != 1) begin
                   checks++; if (bm.consumer_read_data[c] !== hash(addr[c]) || bm.consumer_write_ready[c] !== 1'b0) begin failures++; $display("FAIL rand_read_data c%0d got %h wr=%b want %h/0", c, bm.consumer_read_data[c], bm.consumer_write_ready[c], hash(addr[c])); end
                 end else begin
                   checks++; if (bm.consumer_read_ready[c] !== 1'b0 || !fwd[c]) begin failures++; $display("FAIL rand_write_done c%0d got rr=%b fwd=%0d want 0/1", c, bm.consumer_read_ready[c], fwd[c]); end
                 end
                 bm.consumer_read_valid[c] = 1'b0;
                 bm.consumer_write_valid[c] = 1'b0;
                 phase[c] = 2;
               end else if (age[c] > 60) begin
                 checks++; failures++; $display("FAIL rand_stuck c%0d got no ready after %0d cycles want <=60", c, age[c]);
                 age[c] = 0;
               end
             end
          default: if (!bm.consumer_read_ready[c] && !bm.consumer_write_ready[c]) begin
                     phase[c] = 0; delay[c] = $urandom_range(0, 3);
                   end
        endcase
      end
    end
    checks++; if (served < 40) begin failures++; $display("FAIL rand_throughput got %0d transactions want >=40", served); end
    checks++; if (bm.timeout_flag !== 2'b00) begin failures++; $display("FAIL rand_no_timeout got %b want 00", bm.timeout_flag); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_exclusivity();
    test_fairness();
    test_priority();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
